// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX arbiter and its round-robin picker.
package uart_pkg;

    localparam int DEFAULT_DATA_BITS = 8;
    localparam int MAX_REQ           = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARB       = 3'd1,
        LAUNCH    = 3'd2,
        WAIT_DONE = 3'd3,
        NEXT      = 3'd4
    } state_t;

    typedef struct packed {
        logic        found;
        logic [31:0] idx;
    } rr_pick_t;

    // First set bit of valid at or after ptr, wrapping modulo n.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [2:0]         ptr,
                                         input int                 n);
        rr_pick_t   r;
        logic [2:0] pos;
        r = '0;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            pos = 3'((int'(ptr) + k) % n);
            if (k < n && valid[pos]) begin
                r.found = 1'b1;
                r.idx   = 32'(pos);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter signals shared between the arbiter and its environment.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = 8
);
    // A requester holds req_valid/req_data/req_last steady until it sees its
    // req_ready bit; the byte was captured on the edge that raised req_ready,
    // so the requester advances to its next byte (or drops valid) right after.
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*DATA_BITS-1:0] req_data;
    logic [NUM_REQ-1:0]           req_last;
    logic [NUM_REQ-1:0]           req_ready;
    logic                         tx_start;
    logic [DATA_BITS-1:0]         tx_din;
    logic                         tx_done;

    modport master (
        output req_valid, req_data, req_last, tx_done,
        input  req_ready, tx_start, tx_din
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_done,
        output req_ready, tx_start, tx_din
    );
endinterface

// File: rtl/uart_rr_arbiter.sv
// Round-robin picker: combinational choice from a registered priority pointer.
module uart_rr_arbiter
    import uart_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] valid,
    input  logic               rotate,
    input  logic [IW-1:0]      rotate_from,
    output logic               found,
    output logic [IW-1:0]      pick,
    output logic [IW-1:0]      ptr
);

    rr_pick_t sel;

    always_comb begin
        sel   = rr_pick(MAX_REQ'(valid), 3'(ptr), NUM_REQ);
        found = sel.found;
        pick  = IW'(sel.idx);
    end

    // Priority moves to the requester just past the one whose turn ended.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (rotate) begin
            ptr <= (rotate_from == IW'(NUM_REQ - 1)) ? '0 : rotate_from + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART byte transmitter among NUM_REQ requesters with round-robin
// bursts and a watchdog on the transmitter's done pulse.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_BITS  = DEFAULT_DATA_BITS,
    parameter  int MAX_BURST  = 4,
    parameter  int START_HOLD = 16,
    parameter  int TIMEOUT    = 4096,
    localparam int IW         = $clog2(NUM_REQ)
) (
    input  logic              clk,
    input  logic              reset,
    uart_tx_arbiter_if.slave  bus,
    output logic [IW-1:0]     grant_id,
    output logic              busy,
    output logic              timeout_err,
    output state_t            dbg_state,
    output logic [IW-1:0]     dbg_rr_ptr
);

    localparam int HW = $clog2(START_HOLD + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        state;
    logic [2:0]    done_sync;
    logic          done_seen;
    logic          last_q;
    logic [HW-1:0] hold_cnt;
    logic [TW-1:0] to_cnt;
    logic [3:0]    burst_cnt;

    logic          arb_found;
    logic [IW-1:0] arb_pick;
    logic          done_edge;
    logic          any_valid;
    logic          grant_valid;
    logic [3:0]    burst_inc;
    logic          end_burst;
    logic          hold_done;
    logic          byte_done;
    logic          expired;
    logic          rotate;
    state_t        fin_state;
    logic [3:0]    fin_burst;

    uart_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk         (clk),
        .reset       (reset),
        .valid       (bus.req_valid),
        .rotate      (rotate),
        .rotate_from (grant_id),
        .found       (arb_found),
        .pick        (arb_pick),
        .ptr         (dbg_rr_ptr)
    );

    always_comb begin
        done_edge   = done_sync[1] & ~done_sync[2];
        any_valid   = |bus.req_valid;
        grant_valid = bus.req_valid[grant_id];
        burst_inc   = burst_cnt + 4'd1;
        end_burst   = last_q || (burst_inc == 4'(MAX_BURST)) || !grant_valid;
        hold_done   = (state == LAUNCH) && (hold_cnt == HW'(START_HOLD));
        // A done edge caught during LAUNCH is completed once the hold expires.
        byte_done   = ((state == WAIT_DONE) && done_edge) ||
                      (hold_done && (done_seen || done_edge));
        expired     = ((state == LAUNCH) || (state == WAIT_DONE)) &&
                      (to_cnt == TW'(TIMEOUT - 1)) && !done_seen && !done_edge;
        rotate      = (byte_done && end_burst) || expired;
        fin_state   = end_burst ? (any_valid ? ARB : IDLE) : NEXT;
        fin_burst   = end_burst ? 4'd0 : burst_inc;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            done_sync   <= '0;
            done_seen   <= 1'b0;
            last_q      <= 1'b0;
            hold_cnt    <= '0;
            to_cnt      <= '0;
            burst_cnt   <= '0;
            grant_id    <= '0;
            timeout_err <= 1'b0;
            bus.req_ready <= '0;
            bus.tx_start  <= 1'b0;
            bus.tx_din    <= '0;
        end else begin
            done_sync     <= {done_sync[1:0], bus.tx_done};
            bus.req_ready <= '0;
            case (state)
                IDLE: begin
                    if (any_valid) state <= ARB;
                end
                ARB: begin
                    if (arb_found) begin
                        grant_id      <= arb_pick;
                        bus.tx_din    <= bus.req_data[arb_pick*DATA_BITS +: DATA_BITS];
                        last_q        <= bus.req_last[arb_pick];
                        bus.req_ready <= NUM_REQ'(1) << arb_pick;
                        hold_cnt      <= '0;
                        to_cnt        <= '0;
                        done_seen     <= 1'b0;
                        state         <= LAUNCH;
                    end else begin
                        state <= IDLE;
                    end
                end
                LAUNCH: begin
                    to_cnt <= to_cnt + 1'b1;
                    if (done_edge) done_seen <= 1'b1;
                    if (expired) begin
                        bus.tx_start <= 1'b0;
                        timeout_err  <= 1'b1;
                        burst_cnt    <= '0;
                        state        <= IDLE;
                    end else if (hold_done) begin
                        bus.tx_start <= 1'b0;
                        if (byte_done) begin
                            burst_cnt <= fin_burst;
                            state     <= fin_state;
                        end else begin
                            state <= WAIT_DONE;
                        end
                    end else begin
                        bus.tx_start <= 1'b1;
                        hold_cnt     <= hold_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    to_cnt <= to_cnt + 1'b1;
                    if (byte_done) begin
                        burst_cnt <= fin_burst;
                        state     <= fin_state;
                    end else if (expired) begin
                        timeout_err <= 1'b1;
                        burst_cnt   <= '0;
                        state       <= IDLE;
                    end
                end
                NEXT: begin
                    if (grant_valid) begin
                        bus.tx_din    <= bus.req_data[grant_id*DATA_BITS +: DATA_BITS];
                        last_q        <= bus.req_last[grant_id];
                        bus.req_ready <= NUM_REQ'(1) << grant_id;
                        hold_cnt      <= '0;
                        to_cnt        <= '0;
                        done_seen     <= 1'b0;
                        state         <= LAUNCH;
                    end else begin
                        // Requester withdrew between bytes; re-arbitrate from scratch.
                        burst_cnt <= '0;
                        state     <= ARB;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: table of expected accepted bytes per phase
// plus hand sequences for held done, timeout and mid-byte reset.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int DW      = 8;
    localparam int NVEC    = 19;
    localparam int NPH     = 5;

    typedef struct {
        int         phase;
        int         id;
        logic [7:0] data;
        logic       last;
        int         ptr;
    } vec_t;

    typedef struct {
        int   delay;
        int   drop;
        int   exp_ptr;
        logic exp_err;
    } phase_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [1:0]   grant_id;
    logic         busy;
    logic         timeout_err;
    state_t       dbg_state;
    logic [1:0]   dbg_rr_ptr;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_BITS(DW)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_BITS(DW), .MAX_BURST(4), .START_HOLD(16), .TIMEOUT(4096)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err),
        .dbg_state   (dbg_state),
        .dbg_rr_ptr  (dbg_rr_ptr)
    );

    // clock / reset
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_fail   = 0;

    logic [13:0] exp_q[$];
    logic [8:0]  rq[NUM_REQ][$];
    vec_t        vecs[NVEC];
    phase_t      phases[NPH];

    int   cur_delay   = 20;
    int   drop_left   = 0;
    logic tx_manual   = 1'b0;
    logic man_done    = 1'b0;
    int   ld_cyc      = 0;
    logic lat_pending = 1'b0;
    int   last_ready_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic load(input int id, input logic [7:0] data, input logic last, input int ptr);
        rq[id].push_back({last, data});
        exp_q.push_back({3'(id), data, 3'(ptr)});
    endtask

    task automatic wait_idle(input int limit);
        int t;
        t = 0;
        @(negedge clk);
        while (t < limit && !(exp_q.size() == 0 && !busy)) begin
            @(negedge clk);
            t++;
        end
        check("idle_wait_queue", exp_q.size(), 0);
        check("idle_wait_busy", busy, 0);
    endtask

    task automatic wait_state(input state_t s, input int limit);
        int t;
        t = 0;
        while (t < limit && dbg_state != s) begin
            @(negedge clk);
            t++;
        end
        check("reach_state", dbg_state, s);
    endtask

    // requester driver, scoreboard, transmitter model and output monitors
    initial begin
        logic [NUM_REQ-1:0]    v;
        logic [NUM_REQ*DW-1:0] d;
        logic [NUM_REQ-1:0]    l;
        logic [13:0]           e;
        int   timer, hold_left, run;
        logic mdone, start_q, err_q, din_ok;
        logic [7:0] din_at_start;
        timer = 0; hold_left = 0; run = 0;
        mdone = 0; start_q = 0; err_q = 0; din_ok = 1; din_at_start = '0;
        forever begin
            @(negedge clk);
            if (bus.req_ready != '0) begin
                last_ready_cyc = cyc;
                if (lat_pending) begin
                    check("ready_latency", cyc - ld_cyc, 2);
                    lat_pending = 1'b0;
                end
                if (exp_q.size() == 0) begin
                    check("unexpected_accept", 32'(bus.req_ready), 0);
                end else begin
                    e = exp_q.pop_front();
                    check("accept_id_data_ptr", {18'd0, 3'(grant_id), bus.tx_din, 3'(dbg_rr_ptr)}, 32'(e));
                    check("ready_onehot", 32'(bus.req_ready), 32'(4'b0001 << e[13:11]));
                end
                for (int i = 0; i < NUM_REQ; i++)
                    if (bus.req_ready[i] && rq[i].size() > 0) void'(rq[i].pop_front());
            end
            v = '0; d = '0; l = '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (rq[i].size() > 0) begin
                    v[i]          = 1'b1;
                    d[i*DW +: DW] = rq[i][0][7:0];
                    l[i]          = rq[i][0][8];
                end
            end
            if (v != '0 && bus.req_valid == '0) begin
                ld_cyc      = cyc;
                lat_pending = 1'b1;
            end
            bus.req_valid = v;
            bus.req_data  = d;
            bus.req_last  = l;

            if (tx_manual) begin
                timer = 0; hold_left = 0; mdone = 0;
            end else begin
                if (hold_left > 0) begin mdone = 1; hold_left--; end
                else mdone = 0;
                if (timer > 0) begin
                    timer--;
                    if (timer == 0) hold_left = 2;
                end
            end
            if (bus.tx_start && !start_q) begin
                check("start_after_ready", cyc - last_ready_cyc, 1);
                run = 0;
                din_at_start = bus.tx_din;
                din_ok = 1'b1;
                if (!tx_manual) begin
                    if (drop_left > 0) drop_left--;
                    else timer = cur_delay;
                end
            end
            if (bus.tx_start) begin
                run++;
                if (bus.tx_din != din_at_start) din_ok = 1'b0;
            end
            if (!bus.tx_start && start_q) begin
                check("start_hold_len", run, 16);
                check("din_stable", din_ok, 1);
            end
            if (timeout_err && !err_q) begin
                check("timeout_at", cyc - last_ready_cyc, 4096);
                check("timeout_start_low", bus.tx_start, 0);
            end
            start_q = bus.tx_start;
            err_q   = timeout_err;
            bus.tx_done = tx_manual ? man_done : mdone;
        end
    end

    initial begin
        // phase, id, data, last, expected rr pointer at acceptance
        vecs[0]  = '{0, 0, 8'hA5, 1'b1, 0};
        vecs[1]  = '{1, 1, 8'h10, 1'b0, 1};
        vecs[2]  = '{1, 1, 8'h11, 1'b0, 1};
        vecs[3]  = '{1, 1, 8'h12, 1'b0, 1};
        vecs[4]  = '{1, 1, 8'h13, 1'b0, 1};
        vecs[5]  = '{1, 3, 8'h30, 1'b0, 2};
        vecs[6]  = '{1, 3, 8'h31, 1'b0, 2};
        vecs[7]  = '{1, 3, 8'h32, 1'b0, 2};
        vecs[8]  = '{1, 3, 8'h33, 1'b0, 2};
        vecs[9]  = '{1, 1, 8'h14, 1'b0, 0};
        vecs[10] = '{1, 1, 8'h15, 1'b0, 0};
        vecs[11] = '{1, 3, 8'h34, 1'b0, 2};
        vecs[12] = '{1, 3, 8'h35, 1'b0, 2};
        vecs[13] = '{2, 1, 8'h40, 1'b1, 0};
        vecs[14] = '{3, 2, 8'h11, 1'b0, 2};
        vecs[15] = '{3, 2, 8'h22, 1'b1, 2};
        vecs[16] = '{3, 0, 8'h33, 1'b1, 3};
        vecs[17] = '{4, 1, 8'h44, 1'b1, 1};
        vecs[18] = '{4, 3, 8'h55, 1'b1, 2};
        // done delay, launches left unanswered, end pointer, end error flag
        phases[0] = '{300, 0, 1, 1'b0};
        phases[1] = '{20,  0, 0, 1'b0};
        phases[2] = '{20,  0, 2, 1'b0};
        phases[3] = '{20,  0, 1, 1'b0};
        phases[4] = '{20,  1, 0, 1'b1};

        bus.req_valid = '0; bus.req_data = '0; bus.req_last = '0; bus.tx_done = 1'b0;
        #3;
        check("rst_tx_start", bus.tx_start, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", 32'(bus.req_ready), 0);
        check("rst_state", dbg_state, IDLE);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        for (int p = 0; p < NPH; p++) begin
            cur_delay = phases[p].delay;
            drop_left = phases[p].drop;
            @(negedge clk); #1;
            for (int k = 0; k < NVEC; k++)
                if (vecs[k].phase == p) load(vecs[k].id, vecs[k].data, vecs[k].last, vecs[k].ptr);
            wait_idle(20000);
            check($sformatf("ph%0d_state", p), dbg_state, IDLE);
            check($sformatf("ph%0d_rr_ptr", p), 32'(dbg_rr_ptr), phases[p].exp_ptr);
            check($sformatf("ph%0d_timeout_err", p), timeout_err, phases[p].exp_err);
        end

        // tx_done held high across the next byte counts only once
        tx_manual = 1'b1;
        man_done  = 1'b0;
        @(negedge clk); #1;
        load(0, 8'h66, 1'b0, 0);
        load(0, 8'h77, 1'b1, 0);
        @(negedge clk);
        wait_state(WAIT_DONE, 200);
        man_done = 1'b1;
        repeat (50) @(negedge clk);
        check("held_done_next_accepted", exp_q.size(), 0);
        check("held_done_counts_once", dbg_state, WAIT_DONE);
        man_done = 1'b0;
        repeat (5) @(negedge clk);
        check("held_done_still_waiting", dbg_state, WAIT_DONE);
        man_done = 1'b1;
        repeat (2) @(negedge clk);
        man_done = 1'b0;
        wait_idle(200);
        check("held_done_rr_ptr", 32'(dbg_rr_ptr), 1);

        // reset while waiting for done
        tx_manual = 1'b0;
        cur_delay = 300;
        @(negedge clk); #1;
        load(2, 8'h88, 1'b1, 1);
        @(negedge clk);
        wait_state(WAIT_DONE, 200);
        tx_manual = 1'b1;
        #3;
        reset = 1'b0;
        #1;
        check("mid_rst_tx_start", bus.tx_start, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_grant", 32'(grant_id), 0);
        check("mid_rst_din", 32'(bus.tx_din), 0);
        check("mid_rst_err", timeout_err, 0);
        check("mid_rst_ptr", 32'(dbg_rr_ptr), 0);
        check("mid_rst_state", dbg_state, IDLE);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        tx_manual = 1'b0;
        cur_delay = 20;
        @(negedge clk); #1;
        load(0, 8'h99, 1'b1, 0);
        load(3, 8'hAA, 1'b1, 1);
        wait_idle(2000);
        check("post_rst_rr_ptr", 32'(dbg_rr_ptr), 0);
        check("post_rst_err", timeout_err, 0);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
